// File: rtl/text_buffer_ctl.sv
// 16x16 character-cell text RAM with a cursor-driven write port and a
// clear sequencer that fills the screen after reset and on command.
module text_buffer_ctl #(
  parameter logic [7:0] CLEAR_CHAR   = 8'h20,
  parameter logic [7:0] NEWLINE_CHAR = 8'h0A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  output logic [7:0] char_code,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       cmd_clear,
  input  logic       cmd_home,
  output logic       busy,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y
);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e     state_q, state_d;
  logic [7:0] clr_addr_q, clr_addr_d;
  logic [3:0] cursor_x_q, cursor_x_d;
  logic [3:0] cursor_y_q, cursor_y_d;
  logic [7:0] char_code_q;

  logic [7:0] mem [256];
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       wr_fire;

  assign busy     = (state_q == StClear);
  assign wr_ready = (state_q == StIdle) && !cmd_clear;
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_addr_q;
    mem_wdata  = CLEAR_CHAR;

    unique case (state_q)
      StClear: begin
        mem_we     = 1'b1;
        clr_addr_d = clr_addr_q + 8'd1;
        if (cmd_clear) begin
          clr_addr_d = 8'd0;
        end else if (clr_addr_q == 8'hFF) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (cmd_clear) begin
          state_d    = StClear;
          clr_addr_d = 8'd0;
        end else if (wr_fire) begin
          if (wr_char == NEWLINE_CHAR) begin
            cursor_x_d = 4'd0;
            cursor_y_d = cursor_y_q + 4'd1;
          end else begin
            mem_we     = 1'b1;
            mem_waddr  = {cursor_x_q, cursor_y_q};
            mem_wdata  = wr_char;
            cursor_x_d = cursor_x_q + 4'd1;
            if (cursor_x_q == 4'hF) begin
              cursor_y_d = cursor_y_q + 4'd1;
            end
          end
        end
      end
      default: state_d = StClear;
    endcase

    // Home and clear both override any cursor advance from a same-cycle write.
    if (cmd_clear || cmd_home) begin
      cursor_x_d = 4'd0;
      cursor_y_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StClear;
      clr_addr_q  <= 8'd0;
      cursor_x_q  <= 4'd0;
      cursor_y_q  <= 4'd0;
      char_code_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      cursor_x_q  <= cursor_x_d;
      cursor_y_q  <= cursor_y_d;
      char_code_q <= busy ? CLEAR_CHAR : mem[char_xy];
    end
  end

  // RAM has no reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign char_code = char_code_q;
  assign cursor_x  = cursor_x_q;
  assign cursor_y  = cursor_y_q;

endmodule

// File: tb/tb_text_buffer_ctl.sv
// Directed self-checking bench for text_buffer_ctl.
module tb_text_buffer_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_xy;
  logic [7:0] char_code;
  logic       wr_valid;
  logic [7:0] wr_char;
  logic       wr_ready;
  logic       cmd_clear;
  logic       cmd_home;
  logic       busy;
  logic [3:0] cursor_x;
  logic [3:0] cursor_y;

  int errors = 0;
  int checks = 0;

  text_buffer_ctl dut (
    .clk      (clk),
    .rst      (rst),
    .char_xy  (char_xy),
    .char_code(char_code),
    .wr_valid (wr_valid),
    .wr_char  (wr_char),
    .wr_ready (wr_ready),
    .cmd_clear(cmd_clear),
    .cmd_home (cmd_home),
    .busy     (busy),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] ch);
    wr_valid = 1'b1;
    wr_char  = ch;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, output logic [7:0] code);
    char_xy = addr;
    tick();
    code = char_code;
  endtask

  // Counts busy cycles until busy drops, also flagging any non-space read.
  task automatic count_busy(input int start, output int n, output bit bad);
    n   = start;
    bad = 1'b0;
    while (busy && n < 1000) begin
      tick();
      n++;
      if (char_code !== 8'h20) bad = 1'b1;
    end
  endtask

  initial begin
    int n;
    bit bad;
    logic [7:0] code;

    rst = 1'b1; char_xy = 8'h37; wr_valid = 1'b0; wr_char = 8'h00;
    cmd_clear = 1'b0; cmd_home = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 1);
    check("rst_ready", wr_ready, 0);
    check("rst_cur", {cursor_x, cursor_y}, 8'h00);
    check("rst_code", char_code, 8'h00);

    rst = 1'b0;
    count_busy(0, n, bad);
    check("clr_len", n, 256);
    check("clr_code", bad, 0);
    check("clr_ready", wr_ready, 1);
    rd(8'h37, code);
    check("rd_cleared", code, 8'h20);

    wr_valid = 1'b1; wr_char = 8'h41; #1;
    check("rdyA", wr_ready, 1);
    tick();
    check("curA", {cursor_x, cursor_y}, 8'h10);
    wr_char = 8'h42; #1;
    check("rdyB", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    check("curB", {cursor_x, cursor_y}, 8'h20);
    rd(8'h00, code);
    check("rdA", code, 8'h41);
    rd(8'h10, code);
    check("rdB", code, 8'h42);

    // Move to (15,15): newlines to row 15, then 15 characters across.
    for (int i = 0; i < 15; i++) wr(8'h0A);
    check("cur_nl15", {cursor_x, cursor_y}, 8'h0F);
    for (int i = 0; i < 15; i++) wr(8'h2E);
    check("cur_ff", {cursor_x, cursor_y}, 8'hFF);
    wr(8'h5A);
    check("cur_wrap", {cursor_x, cursor_y}, 8'h00);
    rd(8'hFF, code);
    check("rdFF", code, 8'h5A);

    for (int i = 0; i < 3; i++) wr(8'h0A);
    for (int i = 0; i < 5; i++) wr(8'h78);
    check("cur53", {cursor_x, cursor_y}, 8'h53);
    wr(8'h0A);
    check("cur_nl", {cursor_x, cursor_y}, 8'h04);
    rd(8'h53, code);
    check("rd53", code, 8'h20);
    rd(8'h43, code);
    check("rd43", code, 8'h78);

    cmd_home = 1'b1; tick(); cmd_home = 1'b0;
    check("home", {cursor_x, cursor_y}, 8'h00);
    wr(8'h0A); wr(8'h0A); wr(8'h61); wr(8'h62);
    check("cur22", {cursor_x, cursor_y}, 8'h22);
    char_xy = 8'h22; wr_valid = 1'b1; wr_char = 8'h31;
    tick();
    wr_valid = 1'b0;
    check("coll_old", char_code, 8'h20);
    tick();
    check("coll_new", char_code, 8'h31);

    cmd_home = 1'b1; tick(); cmd_home = 1'b0;
    wr(8'h0A);
    for (int i = 0; i < 7; i++) wr(8'h30);
    check("cur71", {cursor_x, cursor_y}, 8'h71);
    wr_valid = 1'b1; wr_char = 8'h55; cmd_home = 1'b1;
    tick();
    wr_valid = 1'b0; cmd_home = 1'b0;
    check("home_wr_cur", {cursor_x, cursor_y}, 8'h00);
    rd(8'h71, code);
    check("home_wr_mem", code, 8'h55);
    rd(8'h61, code);
    check("rd61", code, 8'h30);

    wr(8'h0A); wr(8'h0A); wr(8'h0A);
    wr_valid = 1'b1; wr_char = 8'h66; cmd_clear = 1'b1; #1;
    check("clr_ready0", wr_ready, 0);
    tick();
    wr_valid = 1'b0; cmd_clear = 1'b0;
    check("cmdclr_busy", busy, 1);
    check("cmdclr_cur", {cursor_x, cursor_y}, 8'h00);
    count_busy(0, n, bad);
    check("cmdclr_len", n, 256);
    check("cmdclr_code", bad, 0);
    rd(8'h03, code);
    check("rd03_clr", code, 8'h20);
    rd(8'h71, code);
    check("rd71_clr", code, 8'h20);

    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    n = 0;
    for (int i = 0; i < 99; i++) begin
      tick();
      n++;
    end
    check("ext_busy99", busy, 1);
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    count_busy(n + 1, n, bad);
    check("ext_len", n, 356);

    wr(8'h44); wr(8'h45);
    check("pre_rst_cur", {cursor_x, cursor_y}, 8'h20);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_cur", {cursor_x, cursor_y}, 8'h00);
    check("mid_rst_busy", busy, 1);
    count_busy(0, n, bad);
    check("mid_rst_len", n, 256);
    rd(8'h00, code);
    check("mid_rst_rd", code, 8'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_buffer_ctl.md
Name: text_buffer_ctl

Overview:
- 16x16 character-cell text RAM plus write controller. Sits directly upstream of the character-drawing stage.
- Translates the drawer's registered `char_xy` cell address into a character code. An external font ROM turns that code plus `char_line` into `char_pixels`.
- Game logic writes text through a valid/ready port with an auto-advancing cursor. A sequencer clears the whole screen after reset and on command.

Parameters:
- CLEAR_CHAR, 8'h20, code written into every cell during a clear (space).
- NEWLINE_CHAR, 8'h0A, control code that moves the cursor instead of being stored.

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst  in  1  reset; synchronous, active-high.
- char_xy  in  8  read address {col[3:0], row[3:0]} from the drawing stage.
- char_code  out  8  registered character code for char_xy.
- wr_valid  in  1  write request.
- wr_char  in  8  character to write / control code.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- cmd_clear  in  1  single-cycle request: clear screen and home cursor.
- cmd_home  in  1  single-cycle request: cursor to (0,0), memory untouched.
- busy  out  1  high while clear sequence runs.
- cursor_x  out  4  current write column.
- cursor_y  out  4  current write row.

Behaviour:
- Storage: 256 x 8 bit, address {col,row}. One sync write port (sequencer or writer), one sync read port.
- Read path:
  - char_code <= busy ? CLEAR_CHAR : mem[char_xy]. Latency exactly 1 clk.
  - Read and write to the same address in the same cycle returns the old data.
- FSM states: CLEAR, IDLE.
- Reset (rst=1), required values:
  - state=CLEAR, clr_addr=0.
  - cursor_x=0, cursor_y=0, char_code=8'h00.
  - busy=1, wr_ready=0.
- CLEAR state:
  - Each cycle writes CLEAR_CHAR to mem[clr_addr], then clr_addr+1.
  - After writing address 255, next state is IDLE.
  - busy=1 for exactly 256 cycles after rst deasserts, or after the cmd_clear cycle.
  - wr_ready=0 throughout.
  - cmd_clear during CLEAR restarts clr_addr at 0; busy is extended accordingly.
  - cmd_home during CLEAR is ignored; the cursor is already 0,0.
- IDLE state:
  - busy=0.
  - wr_ready = ~cmd_clear. Combinational; cmd_clear has priority.
  - cmd_clear=1: next state CLEAR, clr_addr=0, cursor=(0,0). Any wr_valid in that cycle is not accepted.
  - cmd_home=1 (and no cmd_clear): cursor=(0,0). A write accepted in the same cycle goes to the old cursor position; the cursor then ends at (0,0), and home wins over advance.
- Accepted transfer (wr_valid & wr_ready):
  - If wr_char == NEWLINE_CHAR: nothing is stored; cursor_x=0, cursor_y=cursor_y+1 (4-bit wrap 15->0).
  - Otherwise: mem[{cursor_x,cursor_y}] <= wr_char, then advance:
    - x<15: x+1.
    - x=15: x=0, y+1.
    - (15,15) wraps to (0,0).
  - One transfer per cycle max. Back-to-back transfers are sustained at 1/cycle with no bubbles.
- Output timing:
  - cursor_x/cursor_y are registers and update on the clock edge that accepts the transfer.
  - busy and wr_ready are derived from state only, plus cmd_clear for wr_ready.
- Reset mid-clear or mid-stream restarts the full clear sequence; there is no partial state retention.

Test Plan:
- Release rst, drive char_xy=8'h37 constantly:
  - busy=1 for exactly 256 cycles, char_code=8'h20 throughout.
  - wr_ready rises the same cycle busy falls.
  - Read char_xy=any → 8'h20.
- After clear, write 'A' (8'h41), 'B' back-to-back:
  - wr_ready held 1, cursor goes (1,0) then (2,0).
  - char_xy=8'h00 → char_code=8'h41 one cycle later; 8'h10 → 8'h42.
- Cursor at (15,15), write 8'h5A:
  - mem[8'hFF]=8'h5A, cursor wraps to (0,0).
  - Then write NEWLINE_CHAR from (5,3): cursor=(0,4), mem[8'h53] unchanged.
- wr_valid=1 with cmd_clear=1 in the same IDLE cycle:
  - wr_ready=0, no write, busy=1 next cycle for 256 cycles, cursor=(0,0).
  - A second cmd_clear 100 cycles into the clear extends busy to 356 total cycles.
- Read/write collision: write 8'h31 at (2,2) while char_xy=8'h22 → char_code shows old 8'h20 next cycle, 8'h31 the cycle after.
- cmd_home together with an accepted write at (7,1): cell 8'h71 updated, cursor ends (0,0). Assert rst for 1 cycle mid-stream → cursor (0,0), full 256-cycle clear repeats.
